// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - channel scan sequencer for a 4x1 mux with framed valid/ready output
//
// Walks mux channels 0..3 and holds each select for SETTLE_CYCLES cycles.
// It then samples the mux output once for that channel. The four samples are
// packed into frame[3:0] and handed downstream over valid/ready.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        one-cycle scan request, ignored while busy
//   cont         continuous mode, sampled when a frame completes
//   mux_o        output of the downstream 4x1 mux
//   sel_s1/s0    mux select, registered (equals the current channel)
//   busy         scan in progress
//   frame        frame[i] = mux_o sampled on channel i
//   frame_valid  frame holds an unconsumed result
//   frame_ready  consumer accepts frame when frame_valid && frame_ready
//   overrun      sticky, a completed frame was dropped
//   clr_ovr      clears overrun (a simultaneous new overrun wins)

module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_o,
  output logic       sel_s1,
  output logic       sel_s0,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       overrun,
  input  logic       clr_ovr
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] ch;
  logic [3:0] cnt;
  logic [2:0] shadow;   // channel 3 never needs storing: it goes straight into the frame
  logic       frame_done;

  // Select comes straight from the channel register so it only moves on a clock edge.
  assign sel_s1 = ch[1];
  assign sel_s0 = ch[0];

  assign frame_done = (state == SAMPLE) && (ch == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= 2'd0;
      cnt         <= 4'd0;
      shadow      <= 3'b000;
      busy        <= 1'b0;
      frame       <= 4'b0000;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SETTLE;
            ch    <= 2'd0;
            cnt   <= 4'd0;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          cnt <= 4'd0;
          if (ch != 2'd3) begin
            shadow[ch] <= mux_o;
            ch         <= ch + 2'd1;
            state      <= SETTLE;
          end else begin
            ch <= 2'd0;
            if (cont) begin
              state <= SETTLE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // A completing frame may load in the same cycle the old one is accepted;
      // in that case valid simply stays high with the new data.
      if (frame_done && (!frame_valid || frame_ready)) begin
        frame       <= {mux_o, shadow};
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      // Set is written last so it beats a simultaneous clear.
      if (clr_ovr) begin
        overrun <= 1'b0;
      end
      if (frame_done && frame_valid && !frame_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl (SETTLE_CYCLES=2 and =1)

module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n_i       [2];
  logic       start_i       [2];
  logic       cont_i        [2];
  logic       ready_i       [2];
  logic       clr_i         [2];
  logic [3:0] d             [2];
  logic       mux_o_i       [2];
  logic       s1_o          [2];
  logic       s0_o          [2];
  logic       busy_o        [2];
  logic [3:0] frame_o       [2];
  logic       fv_o          [2];
  logic       ovr_o         [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  assign mux_o_i[0] = d[0][{s1_o[0], s0_o[0]}];
  assign mux_o_i[1] = d[1][{s1_o[1], s0_o[1]}];

  mux_scan_ctrl #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n_i[0]), .start(start_i[0]), .cont(cont_i[0]),
    .mux_o(mux_o_i[0]), .sel_s1(s1_o[0]), .sel_s0(s0_o[0]), .busy(busy_o[0]),
    .frame(frame_o[0]), .frame_valid(fv_o[0]), .frame_ready(ready_i[0]),
    .overrun(ovr_o[0]), .clr_ovr(clr_i[0])
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n_i[1]), .start(start_i[1]), .cont(cont_i[1]),
    .mux_o(mux_o_i[1]), .sel_s1(s1_o[1]), .sel_s0(s0_o[1]), .busy(busy_o[1]),
    .frame(frame_o[1]), .frame_valid(fv_o[1]), .frame_ready(ready_i[1]),
    .overrun(ovr_o[1]), .clr_ovr(clr_i[1])
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a scan is a run of 4*(S+1) cycles counted by m_pos;
  // the channel is m_pos/(S+1) and the last cycle of each channel samples.
  int       settle [2] = '{2, 1};
  bit       m_busy [2] = '{0, 0};
  int       m_pos  [2] = '{0, 0};
  bit [3:0] m_bits [2] = '{4'b0, 4'b0};
  bit [3:0] m_frame[2] = '{4'b0, 4'b0};
  bit       m_valid[2] = '{0, 0};
  bit       m_ovr  [2] = '{0, 0};

  task automatic model_step(int k, bit r, bit st, bit ct, bit rd, bit cl, bit [3:0] dd);
    int per;
    int ch;
    bit load;
    bit set_ovr;
    per = settle[k] + 1;
    if (!r) begin
      m_busy[k] = 0; m_pos[k] = 0; m_bits[k] = 0;
      m_frame[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
      return;
    end
    load = 0;
    set_ovr = 0;
    if (!m_busy[k]) begin
      if (st) begin
        m_busy[k] = 1;
        m_pos[k] = 0;
      end
    end else begin
      ch = m_pos[k] / per;
      if (m_pos[k] % per == per - 1) begin
        m_bits[k][ch] = dd[ch];
        if (ch == 3) begin
          if (!m_valid[k] || rd) load = 1;
          else set_ovr = 1;
        end
      end
      m_pos[k]++;
      if (m_pos[k] == 4 * per) begin
        m_pos[k] = 0;
        if (!ct) m_busy[k] = 0;
      end
    end
    if (load) begin
      m_frame[k] = m_bits[k];
      m_valid[k] = 1;
    end else if (m_valid[k] && rd) begin
      m_valid[k] = 0;
    end
    if (cl) m_ovr[k] = 0;
    if (set_ovr) m_ovr[k] = 1;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      model_step(k, rst_n_i[k], start_i[k], cont_i[k], ready_i[k], clr_i[k], d[k]);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("m_sel%0d", k), {s1_o[k], s0_o[k]},
              m_busy[k] ? (m_pos[k] / (settle[k] + 1)) : 0);
        check($sformatf("m_busy%0d", k), busy_o[k], m_busy[k]);
        check($sformatf("m_valid%0d", k), fv_o[k], m_valid[k]);
        check($sformatf("m_frame%0d", k), frame_o[k], m_frame[k]);
        check($sformatf("m_ovr%0d", k), ovr_o[k], m_ovr[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_edge(int k);
    start_i[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n_i[k] = 1'b0; start_i[k] = 1'b0; cont_i[k] = 1'b0;
      ready_i[k] = 1'b0; clr_i[k] = 1'b0; d[k] = 4'b0000;
    end
    @(negedge clk);
    tick();
    chk_en = 1;
    tick();
    rst_n_i[0] = 1'b1;
    rst_n_i[1] = 1'b1;
    tick();
    check("rst_sel", {s1_o[0], s0_o[0]}, 2'b00);
    check("rst_busy", busy_o[0], 1'b0);
    check("rst_valid", fv_o[0], 1'b0);
    check("rst_frame", frame_o[0], 4'b0000);
    check("rst_ovr", ovr_o[0], 1'b0);
    repeat (10) tick();
    check("idle_valid", fv_o[0], 1'b0);
    check("idle_sel", {s1_o[0], s0_o[0]}, 2'b00);

    // Single scan, data 1010
    d[0] = 4'b1010;
    start_edge(0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i < 12) check("ss_sel", {s1_o[0], s0_o[0]}, i / 3);
      if (i == 11) check("ss_valid_early", fv_o[0], 1'b0);
    end
    check("ss_valid", fv_o[0], 1'b1);
    check("ss_frame", frame_o[0], 4'b1010);
    check("ss_busy", busy_o[0], 1'b0);
    check("ss_sel_end", {s1_o[0], s0_o[0]}, 2'b00);

    // Handshake hold and accept
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hs_hold", frame_o[0], 4'b1010);
    end
    ready_i[0] = 1'b1;
    tick();
    ready_i[0] = 1'b0;
    check("hs_drop", fv_o[0], 1'b0);

    // Continuous with overrun, then simultaneous accept+load
    d[0] = 4'b0110;
    cont_i[0] = 1'b1;
    start_edge(0);
    for (int e = 1; e <= 36; e++) begin
      tick();
      if (e == 12) begin
        check("cont_f1", frame_o[0], 4'b0110);
        d[0] = 4'b1001;
      end
      if (e == 24) begin
        check("cont_drop", frame_o[0], 4'b0110);
        check("cont_ovr", ovr_o[0], 1'b1);
        clr_i[0] = 1'b1;
      end
      if (e == 25) begin
        clr_i[0] = 1'b0;
        check("cont_clr", ovr_o[0], 1'b0);
      end
      if (e == 35) begin
        ready_i[0] = 1'b1;
        cont_i[0] = 1'b0;
      end
    end
    check("cont_f3", frame_o[0], 4'b1001);
    check("cont_f3_valid", fv_o[0], 1'b1);
    check("cont_f3_ovr", ovr_o[0], 1'b0);
    check("cont_idle", busy_o[0], 1'b0);
    tick();
    ready_i[0] = 1'b0;

    // Reset mid-scan, with an ignored start while busy
    start_edge(0);
    repeat (3) tick();
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    check("busy_start_ign", {s1_o[0], s0_o[0]}, 2'b01);
    repeat (2) tick();
    check("mid_sel", {s1_o[0], s0_o[0]}, 2'b10);
    rst_n_i[0] = 1'b0;
    tick();
    rst_n_i[0] = 1'b1;
    check("mid_rst_sel", {s1_o[0], s0_o[0]}, 2'b00);
    check("mid_rst_busy", busy_o[0], 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mid_no_valid", fv_o[0], 1'b0);
    end

    // SETTLE_CYCLES=1 instance
    d[1] = 4'b1111;
    start_edge(1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("s1_valid_early", fv_o[1], 1'b0);
    end
    check("s1_valid", fv_o[1], 1'b1);
    check("s1_frame", frame_o[1], 4'b1111);
    ready_i[1] = 1'b1;
    tick();
    ready_i[1] = 1'b0;

    // Randomized traffic on both instances, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        rst_n_i[k] = ($urandom_range(0, 199) != 0);
        start_i[k] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) cont_i[k] = ~cont_i[k];
        ready_i[k] = ($urandom_range(0, 2) == 0);
        clr_i[k]   = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 7) == 0) d[k] = 4'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 4x1 gate-level multiplexer. It drives the mux select lines (s1, s0), walks channels 0..3, waits a settle interval on each channel, then samples the mux output. It packs the four samples into a 4-bit frame, which it hands downstream over a valid/ready handshake. It supports single-scan and continuous-scan modes, with sticky overrun reporting.

Parameters:
SETTLE_CYCLES, 2, cycles the select is held stable before sampling each channel; legal range 1..15; settle counter is 4 bits.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  reset; synchronous, active-low.
start  input  1  one-cycle request to begin a scan; ignored while busy=1.
cont  input  1  continuous mode; sampled at each frame completion.
mux_o  input  1  output of the downstream 4x1 mux (its o).
sel_s1  output  1  mux select MSB (drives s1).
sel_s0  output  1  mux select LSB (drives s0).
busy  output  1  high from the first scan cycle until return to IDLE.
frame  output  4  frame[i] = mux_o sampled while channel i was selected.
frame_valid  output  1  frame holds an unconsumed result.
frame_ready  input  1  consumer accepts frame when frame_valid&&frame_ready.
overrun  output  1  sticky: a completed frame was dropped.
clr_ovr  input  1  clears overrun.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, ch=0, so sel_s1=0 and sel_s0=0.
  - busy=0, frame=4'b0000, frame_valid=0, overrun=0, shadow=0, settle count=0.
  - Reset mid-scan aborts the scan with no frame emitted.
- {sel_s1,sel_s0} = ch, driven directly from a register. Select never changes except on a clock edge.
- FSM states: IDLE, SETTLE, SAMPLE.
  - IDLE -> SETTLE when start=1. ch<=0, cnt<=0, busy<=1.
  - SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE (one cycle): shadow[ch]<=mux_o.
    - If ch!=3: ch<=ch+1, cnt<=0, go to SETTLE.
    - If ch==3: frame completes (see below). ch<=0.
      - If cont=1: cnt<=0, go to SETTLE.
      - Otherwise: go to IDLE, busy<=0.
- Per-channel cost is SETTLE_CYCLES+1 cycles.
- Latency: frame_valid rises 4*(SETTLE_CYCLES+1) clocks after the edge that samples start=1. With the default, that is 12 clocks.
- Frame completion (at the SAMPLE edge with ch==3):
  - The new frame is {mux_o, shadow[2], shadow[1], shadow[0]}.
  - If frame_valid==0, or frame_ready==1 in the same cycle: frame<=new frame, frame_valid<=1.
  - If frame_valid==1 and frame_ready==0: the new frame is dropped, frame is unchanged, and overrun<=1.
- Handshake:
  - frame_valid deasserts on the edge where frame_valid&&frame_ready, unless a new frame loads in that same cycle; then valid stays 1 with the new data.
  - frame is stable while frame_valid=1 and not accepted.
  - frame_ready while frame_valid=0 has no effect.
- Overrun: clr_ovr=1 clears it. If clr_ovr and a new overrun occur in the same cycle, the set wins (overrun=1).
- start while busy=1 is ignored, including in the SAMPLE cycle of ch 3 in single mode.
- Continuous mode: deasserting cont mid-scan finishes the current frame, then returns to IDLE.
- mux_o is sampled only in SAMPLE. Glitches during SETTLE do not affect the result.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 clocks, then release. Expect sel=00, busy=0, frame_valid=0, frame=0000, overrun=0. Then idle for 10 clocks with no change.
- Single scan: mux model d3..d0=1010, frame_ready=0, pulse start. Expect:
  - sel steps 00->01->10->11, each held 3 clocks.
  - frame_valid=1 exactly 12 clocks after the start edge, frame=4'b1010.
  - busy=0 and sel=00 on the same edge.
- Handshake: with frame_valid=1, hold frame_ready=0 for 5 clocks; frame stays 1010. Raise frame_ready for 1 clock; valid drops the next edge.
- Continuous + overrun: cont=1, frame_ready=0, data 0110. Expect:
  - first frame=0110;
  - change data to 1001; second completion is dropped, frame stays 0110, overrun=1;
  - pulse clr_ovr, overrun=0.
  - Then frame_ready=1: the next frame=1001 loads, with no overrun on the simultaneous accept+load.
- Reset mid-scan: start, then rst_n=0 while sel=10. Expect sel=00, busy=0, no frame_valid pulse afterwards. A start pulsed while busy mid-scan does not restart ch.
- SETTLE_CYCLES=1 instance: data 1111 -> frame_valid 8 clocks after start, frame=4'b1111.
